sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares one EasySDRAM command FIFO port among NUM_PORTS independent requesters, for example a video scanout reader, a CPU bridge and a DMA writer.
- Arbitration is round-robin. Each winning command goes through a one-entry registered output stage that obeys the SDRAM FIFO's write/full handshake.
- The port index of every issued read is recorded in an in-order tag FIFO, so each SDRAM readout is steered back to the port that requested it.
- Sits between the client blocks and EasySDRAM; same clock domain.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- PORT_W, 2, width of a port index; must equal clog2(NUM_PORTS), minimum 1.
- TAG_DEPTH, 512, depth of the in-flight read tag FIFO; must be at least 256 + 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  per-port command valid
- req_ready  out  NUM_PORTS  per-port command accepted this cycle (one-hot or zero)
- req_is_write  in  NUM_PORTS  per-port: 1 = write, 0 = read
- req_addr  in  NUM_PORTS*25  packed per-port address; port i occupies bits [25i+24:25i]
- req_mask  in  NUM_PORTS*2  packed per-port byte mask
- req_wdata  in  NUM_PORTS*16  packed per-port write data
- sd_write  out  1  drives EasySDRAM write
- sd_full  in  1  from EasySDRAM full
- sd_is_write  out  1  to isWrite
- sd_address  out  25  to address
- sd_mask  out  2  to writeMask
- sd_wdata  out  16  to writeData
- sd_read_valid  in  1  from readValid
- sd_raddr  in  25  from raddr
- sd_rdata  in  16  from rdata
- rsp_valid  out  NUM_PORTS  one-hot readout strobe for the owning port
- rsp_addr  out  25  registered readout address, broadcast to all ports
- rsp_data  out  16  registered readout data, broadcast to all ports
- reads_outstanding  out  clog2(TAG_DEPTH)+1  tag FIFO occupancy
- tag_error  out  1  sticky: a readout arrived with no outstanding tag

Behaviour:
- Reset values: sd_write=0, rsp_valid=0, tag_error=0, reads_outstanding=0, round-robin pointer=0, tag FIFO empty. sd_*/rsp_* data outputs are 0.
- Output stage: one register holding {is_write, addr, mask, wdata, port}, plus out_valid; sd_write = out_valid.
  - The stage drains when out_valid & ~sd_full.
  - can_load = ~out_valid | ~sd_full.
- Eligibility: port i is eligible when req_valid[i] is high, and either req_is_write[i] is 1 or the tag FIFO has room.
  - Room means occupancy + (out_valid & ~out_is_write) < TAG_DEPTH.
  - Writes are never blocked by tag FIFO occupancy.
- Grant:
  - When can_load is high, grant the first eligible port at or after the pointer, searching upward and wrapping modulo NUM_PORTS.
  - req_ready is combinational, one-hot, and equals the grant; the winner's fields load into the output stage on that edge.
  - The pointer moves to grant+1, wrapping to 0 after NUM_PORTS-1; with no grant it holds.
- Latency: accepted at edge N, sd_write=1 during cycle N+1. The entry stays presented unchanged while sd_full=1.
- Tag push: when the stage drains and out_is_write=0, push out_port into the tag FIFO.
- Tag pop: when sd_read_valid=1 and the tag FIFO is non-empty, pop the head. Register rsp_addr/rsp_data, and rsp_valid = onehot(head) on the next cycle.
- Readout with no tag: when sd_read_valid=1 and the tag FIFO is empty:
  - set tag_error=1; it stays set until rst;
  - rsp_valid stays 0;
  - a push in the same cycle does not satisfy the pop.
- Push and pop in the same cycle: occupancy is unchanged and FIFO order is preserved.
- Write readouts: none are expected. Every readout is matched to reads in issue order.
- Reset mid-operation: all in-flight tags are discarded. EasySDRAM is reset by the same rst, so no stale readouts follow.

Decomposition:
- sdram_arb_pkg holds:
  - typedef sdram_cmd_t = {is_write, addr[24:0], mask[1:0], wdata[15:0]};
  - constant CMD_FIFO_DEPTH = 256.
- One sub-module, sdram_tag_fifo: a synchronous FIFO of width PORT_W and depth TAG_DEPTH with push, pop, empty, full and count outputs.
  - Pointers wrap modulo TAG_DEPTH.
  - Reads are first-word-fall-through.

Test Plan:
- Single port 0: read at 0x0000123. -> sd_write=1 one cycle after acceptance; reads_outstanding=1. A model readout (raddr 0x0000123, rdata 0xBEEF) produces rsp_valid=4'b0001 with that addr/data the next cycle; count returns to 0.
- All 4 ports valid continuously, sd_full=0. -> grant order 0,1,2,3,0,1,...; req_ready one-hot every cycle; no port starved across 64 grants.
- Force sd_full=1 for 10 cycles with pending commands. -> sd_write held high with stable fields; req_ready=0 throughout; grants resume the cycle sd_full falls.
- Ports 2 and 1 issue interleaved reads; the model returns readouts in order. -> each rsp_valid goes to the correct port: 4'b0100, then 4'b0010, and so on.
- Fill the tag FIFO to TAG_DEPTH with reads and withhold readouts. -> read requests stall while writes from another port are still granted. After one readout, exactly one more read is accepted.
- Inject sd_read_valid with no reads outstanding. -> tag_error=1 sticky; rsp_valid=0. After rst, tag_error=0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the EasySDRAM port arbiter.
package sdram_arb_pkg;

   localparam int CMD_FIFO_DEPTH = 256;

   typedef struct packed {
      logic        is_write;
      logic [24:0] addr;
      logic [1:0]  mask;
      logic [15:0] wdata;
   } sdram_cmd_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of port indices for reads issued to the SDRAM.
module sdram_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 512,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= inc(wr_ptr);
         if (do_pop)  rd_ptr <= inc(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one EasySDRAM command port, with
// in-order steering of read data back to the requesting port.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 2,
   parameter int TAG_DEPTH = 512,
   localparam int CW       = $clog2(TAG_DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_PORTS-1:0]    req_valid,
   output logic [NUM_PORTS-1:0]    req_ready,
   input  logic [NUM_PORTS-1:0]    req_is_write,
   input  logic [NUM_PORTS*25-1:0] req_addr,
   input  logic [NUM_PORTS*2-1:0]  req_mask,
   input  logic [NUM_PORTS*16-1:0] req_wdata,
   output logic                    sd_write,
   input  logic                    sd_full,
   output logic                    sd_is_write,
   output logic [24:0]             sd_address,
   output logic [1:0]              sd_mask,
   output logic [15:0]             sd_wdata,
   input  logic                    sd_read_valid,
   input  logic [24:0]             sd_raddr,
   input  logic [15:0]             sd_rdata,
   output logic [NUM_PORTS-1:0]    rsp_valid,
   output logic [24:0]             rsp_addr,
   output logic [15:0]             rsp_data,
   output logic [CW-1:0]           reads_outstanding,
   output logic                    tag_error
);

   localparam logic [NUM_PORTS-1:0] PORT0 = NUM_PORTS'(1);

   sdram_cmd_t           cmd_in [NUM_PORTS];
   sdram_cmd_t           out_cmd;
   logic                 out_valid;
   logic [PORT_W-1:0]    out_port;
   logic [PORT_W-1:0]    rr_ptr;
   logic [PORT_W-1:0]    gnt_idx;
   logic [PORT_W:0]      sum;
   logic [PORT_W-1:0]    idx;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant;
   logic                 gnt_any;
   logic                 can_load;
   logic                 drain;
   logic                 room;
   logic                 tag_push;
   logic                 tag_pop;
   logic                 tag_empty;
   logic                 tag_full;
   logic [PORT_W-1:0]    tag_head;
   logic [CW-1:0]        tag_count;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign cmd_in[i] = '{req_is_write[i],
                           req_addr[25*i +: 25],
                           req_mask[2*i +: 2],
                           req_wdata[16*i +: 16]};
      assign eligible[i] = req_valid[i] & (req_is_write[i] | room);
   end

   assign drain    = out_valid & ~sd_full;
   assign can_load = ~out_valid | ~sd_full;

   // A read waiting in the output stage already owns a tag slot.
   assign room = ({1'b0, tag_count}
                  + (CW+1)'(out_valid & ~out_cmd.is_write))
                 < (CW+1)'(TAG_DEPTH);

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         sum = {1'b0, rr_ptr} + (PORT_W+1)'(k);
         if (sum >= (PORT_W+1)'(NUM_PORTS))
            sum = sum - (PORT_W+1)'(NUM_PORTS);
         idx = sum[PORT_W-1:0];
         if (can_load && !gnt_any && eligible[idx]) begin
            grant[idx] = 1'b1;
            gnt_idx    = idx;
            gnt_any    = 1'b1;
         end
      end
   end

   assign req_ready = grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         out_cmd   <= '0;
         out_port  <= '0;
      end else begin
         if (gnt_any)
            rr_ptr <= (gnt_idx == PORT_W'(NUM_PORTS - 1))
                      ? '0 : gnt_idx + 1'b1;
         if (can_load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
               out_cmd  <= cmd_in[gnt_idx];
               out_port <= gnt_idx;
            end
         end
      end
   end

   assign sd_write    = out_valid;
   assign sd_is_write = out_cmd.is_write;
   assign sd_address  = out_cmd.addr;
   assign sd_mask     = out_cmd.mask;
   assign sd_wdata    = out_cmd.wdata;

   assign tag_push = drain & ~out_cmd.is_write & ~tag_full;
   assign tag_pop  = sd_read_valid & ~tag_empty;

   sdram_tag_fifo #(
      .W     (PORT_W),
      .DEPTH (TAG_DEPTH)
   ) u_tags (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .din   (out_port),
      .pop   (tag_pop),
      .dout  (tag_head),
      .empty (tag_empty),
      .full  (tag_full),
      .count (tag_count)
   );

   assign reads_outstanding = tag_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
         tag_error <= 1'b0;
      end else begin
         rsp_valid <= tag_pop ? (PORT0 << tag_head) : '0;
         if (tag_pop) begin
            rsp_addr <= sd_raddr;
            rsp_data <= sd_rdata;
         end
         if (sd_read_valid && tag_empty) tag_error <= 1'b1;
      end
   end

endmodule
